mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Round-robin arbiter sharing one memory port among `NUM_REQ` requesters (instruction fetch, data, DMA) in the KianV SoC. It grants one requester at a time and holds the grant for a whole valid/ready transaction. It steers the granted requester's address, data and strobes onto the shared port. A watchdog counter terminates stalled transactions with an error response.

## Interface
- `NUM_REQ`, 3: number of requesters, 2..8.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width; strobe width is `DATA_WIDTH/8`.
- `TIMEOUT`, 1024: cycles in BUSY before forced abort; 0 disables the watchdog.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  flattened; requester i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  flattened write data.
- `req_wstrb`  in  NUM_REQ*DATA_WIDTH/8  flattened byte strobes; all zero means read.
- `req_ready`  out  NUM_REQ  one-hot completion pulse.
- `req_err`  out  NUM_REQ  one-hot; asserted with `req_ready` on timeout.
- `req_rdata`  out  DATA_WIDTH  shared read data; valid only with the `req_ready` bit.
- `mem_valid`  out  1  shared port request.
- `mem_addr`  out  ADDR_WIDTH  muxed address.
- `mem_wdata`  out  DATA_WIDTH  muxed write data.
- `mem_wstrb`  out  DATA_WIDTH/8  muxed strobes.
- `mem_ready`  in  1  shared port completion.
- `mem_rdata`  in  DATA_WIDTH  shared port read data.
- `grant_idx`  out  clog2(NUM_REQ)  current or last grant, for debug.
- `busy`  out  1  high in BUSY.

## Operation
- State machine has two states: IDLE and BUSY. State, `grant_idx` and `last` (the last-served index) are registers.
- In IDLE, if any `req_valid` is set:
  - Select the first set bit scanning `last+1, last+2, …` modulo NUM_REQ.
  - Register the winner into `grant_idx`, clear the watchdog, and go to BUSY.
- In BUSY:
  - `mem_valid`=1, `busy`=1.
  - `mem_addr`, `mem_wdata` and `mem_wstrb` are driven combinationally from requester `grant_idx`.
  - `req_rdata` = `mem_rdata` in all states.
- In BUSY with `mem_ready`=1:
  - `req_ready[grant_idx]`=1 in the same cycle (combinational pass-through).
  - `last`<=`grant_idx`, then IDLE.
- In BUSY with `mem_ready`=0:
  - The watchdog increments.
  - If `TIMEOUT`≠0 and the watchdog equals `TIMEOUT-1`: `req_ready[grant_idx]`=1 and `req_err[grant_idx]`=1 that cycle, then `last`<=`grant_idx` and IDLE.
- If `mem_ready` arrives in the timeout cycle, normal completion wins and `req_err` stays 0.
- All `req_ready` and `req_err` bits not belonging to the granted requester in BUSY are 0. In IDLE all bits are 0.
- Requester protocol: hold `req_valid` and payload stable until `req_ready`. The arbiter never revokes a grant because `req_valid` drops; the transaction runs to `mem_ready` or timeout.
- `mem_ready` while IDLE is ignored.
- Watchdog width is `clog2(TIMEOUT)+1`. It saturates and never wraps.

## Timing
- Reset values: state IDLE, `mem_valid`=0, `busy`=0, `req_ready`=0, `req_err`=0, `grant_idx`=0, watchdog 0, `last`=NUM_REQ-1 (requester 0 has first priority). `mem_addr`, `mem_wdata` and `mem_wstrb` reflect requester 0.
- Reset asserted in BUSY: `mem_valid`=0 from the next cycle. No `req_ready` or `req_err` is issued for the aborted transaction.
- Grant latency: `req_valid` seen in IDLE at cycle N gives `mem_valid`=1 at cycle N+1.
- Completion: `mem_ready` at cycle M gives `req_ready` at cycle M, and IDLE at M+1.
- Minimum spacing between grants is 2 cycles: one BUSY cycle plus one IDLE cycle.
- Timeout: `req_err` pulses at the cycle index `TIMEOUT-1` in BUSY, counting the first BUSY cycle as 0.
- There are no combinational paths from `req_valid` to `mem_*`. The only combinational paths from `mem_ready` go to `req_ready`, `req_err` and `req_rdata`.

## Test plan
- Single request, zero-wait: `req_valid[1]`=1, addr 0x100 at cycle 0, `mem_ready`=1 whenever `mem_valid`.
  - Expect `mem_valid` and `mem_addr`=0x100 at cycle 1.
  - Expect `req_ready`=3'b010 with `req_rdata`=`mem_rdata` at cycle 1.
  - Expect `busy`=0 at cycle 2.
- Fairness: all three `req_valid` held continuously, `mem_ready` immediate.
  - Expect grant order 0,1,2,0,1,2, one grant every 2 cycles.
  - Expect `req_ready` one-hot each time.
- Priority rotation: after serving 2, requesters 0 and 2 both request.
  - Expect 0 to be granted, then 2.
- Timeout with `TIMEOUT`=4: `req_valid[2]`=1, `mem_ready` held 0.
  - Expect `req_ready[2]`=`req_err[2]`=1 exactly at the 4th BUSY cycle.
  - Expect `mem_valid`=0 on the following cycle.
- Timeout race with `TIMEOUT`=4: `mem_ready`=1 on the 4th BUSY cycle.
  - Expect `req_ready[2]`=1 and `req_err`=0.
- Reset mid-transaction: assert `reset` for 1 cycle while BUSY on requester 1.
  - Expect `mem_valid`=0, `busy`=0 and no `req_ready` on the next cycle.
  - Expect the next simultaneous 0/1 request to grant 0 first.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and shared-memory-side signals of the round-robin memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_bus_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*STRB_W-1:0]     req_wstrb;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_err;
  logic [DATA_WIDTH-1:0]         req_rdata;
  logic                          mem_valid;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic [STRB_W-1:0]             mem_wstrb;
  logic                          mem_ready;
  logic [DATA_WIDTH-1:0]         mem_rdata;
  logic [IDX_W-1:0]              grant_idx;
  logic                          busy;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
    output req_ready, req_err, req_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb,
           grant_idx, busy
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
    input  req_ready, req_err, req_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb,
           grant_idx, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters, holding each
// grant for a full valid/ready transaction, with a watchdog that aborts stalled ones.
module mem_bus_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.slave   bus
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int WD_W   = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  grant_q;
  logic [IDX_W-1:0]  last_q;
  logic [WD_W-1:0]   wdog_q;

  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  int                cand;
  logic              in_busy;
  logic              timeout_hit;
  logic [NUM_REQ-1:0] grant_oh;

  // Scan last+1, last+2, ... so the most recently served requester has lowest priority.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_q) + k) % NUM_REQ;
      if (!pick_vld && bus.req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(cand);
      end
    end
  end

  assign in_busy     = (state_q == BUSY);
  assign timeout_hit = (TIMEOUT != 0) && (wdog_q == WD_LAST);
  assign grant_oh    = NUM_REQ'(1) << grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      wdog_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_idx;
            wdog_q  <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ready || timeout_hit) begin
            last_q  <= grant_q;
            state_q <= IDLE;
          end else if (wdog_q != WD_MAX) begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // mem_ready wins over a coincident timeout, so err only flags a genuine abort.
  assign bus.req_ready = (in_busy && (bus.mem_ready || timeout_hit)) ? grant_oh : '0;
  assign bus.req_err   = (in_busy && !bus.mem_ready && timeout_hit) ? grant_oh : '0;
  assign bus.req_rdata = bus.mem_rdata;

  assign bus.mem_valid = in_busy;
  assign bus.busy      = in_busy;
  assign bus.grant_idx = grant_q;
  assign bus.mem_addr  = bus.req_addr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.mem_wdata = bus.req_wdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.mem_wstrb = bus.req_wstrb[int'(grant_q)*STRB_W +: STRB_W];
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a cycle-by-cycle vector table plus hand-written
// sequences for grant hold after req_valid drops and the bounded timeout path.
module tb_mem_bus_arbiter;
  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] A0 = 32'h0000_0040;
  localparam logic [31:0] A1 = 32'h0000_0100;
  localparam logic [31:0] A2 = 32'h0000_0200;
  localparam logic [31:0] W0 = 32'h1111_0000;
  localparam logic [31:0] W1 = 32'h2222_0001;
  localparam logic [31:0] W2 = 32'h3333_0002;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mem_bus_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_bus_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  vld;
    logic        mrdy;
    logic        mv;
    logic [1:0]  g;
    logic [2:0]  rdy;
    logic [2:0]  err;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [2:0] vld, input logic mrdy,
                     input logic mv, input logic [1:0] g, input logic [2:0] rdy,
                     input logic [2:0] err, input logic [31:0] addr);
    vec_t v;
    v.rst = rst; v.vld = vld; v.mrdy = mrdy; v.mv = mv;
    v.g = g; v.rdy = rdy; v.err = err; v.addr = addr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    checks = 0;
    failures = 0;
    bus.req_valid = '0;
    bus.req_addr  = {A2, A1, A0};
    bus.req_wdata = {W2, W1, W0};
    bus.req_wstrb = {4'hF, 4'h3, 4'h1};
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    //   rst vld     mrdy mv g  rdy     err     addr
    add(0, 3'b000, 0, 0, 0, 3'b000, 3'b000, A0); // reset state
    add(0, 3'b000, 1, 0, 0, 3'b000, 3'b000, A0); // mem_ready in IDLE ignored
    add(0, 3'b010, 0, 0, 0, 3'b000, 3'b000, A0); // single request seen
    add(0, 3'b010, 1, 1, 1, 3'b010, 3'b000, A1); // zero-wait completion
    add(0, 3'b000, 0, 0, 1, 3'b000, 3'b000, A1);
    add(1, 3'b111, 0, 0, 1, 3'b000, 3'b000, A1); // reset before fairness run
    add(0, 3'b111, 1, 0, 0, 3'b000, 3'b000, A0);
    add(0, 3'b111, 1, 1, 0, 3'b001, 3'b000, A0);
    add(0, 3'b111, 1, 0, 0, 3'b000, 3'b000, A0);
    add(0, 3'b111, 1, 1, 1, 3'b010, 3'b000, A1);
    add(0, 3'b111, 1, 0, 1, 3'b000, 3'b000, A1);
    add(0, 3'b111, 1, 1, 2, 3'b100, 3'b000, A2);
    add(0, 3'b111, 1, 0, 2, 3'b000, 3'b000, A2);
    add(0, 3'b111, 1, 1, 0, 3'b001, 3'b000, A0);
    add(0, 3'b111, 1, 0, 0, 3'b000, 3'b000, A0);
    add(0, 3'b111, 1, 1, 1, 3'b010, 3'b000, A1);
    add(0, 3'b111, 1, 0, 1, 3'b000, 3'b000, A1);
    add(0, 3'b111, 1, 1, 2, 3'b100, 3'b000, A2);
    add(0, 3'b101, 1, 0, 2, 3'b000, 3'b000, A2); // rotation: 0 and 2 after 2
    add(0, 3'b101, 1, 1, 0, 3'b001, 3'b000, A0);
    add(0, 3'b101, 1, 0, 0, 3'b000, 3'b000, A0);
    add(0, 3'b101, 1, 1, 2, 3'b100, 3'b000, A2);
    add(0, 3'b000, 0, 0, 2, 3'b000, 3'b000, A2);
    add(0, 3'b100, 0, 0, 2, 3'b000, 3'b000, A2); // timeout run
    add(0, 3'b100, 0, 1, 2, 3'b000, 3'b000, A2);
    add(0, 3'b100, 0, 1, 2, 3'b000, 3'b000, A2);
    add(0, 3'b100, 0, 1, 2, 3'b000, 3'b000, A2);
    add(0, 3'b100, 0, 1, 2, 3'b100, 3'b100, A2);
    add(0, 3'b000, 0, 0, 2, 3'b000, 3'b000, A2);
    add(0, 3'b100, 0, 0, 2, 3'b000, 3'b000, A2); // timeout race
    add(0, 3'b100, 0, 1, 2, 3'b000, 3'b000, A2);
    add(0, 3'b100, 0, 1, 2, 3'b000, 3'b000, A2);
    add(0, 3'b100, 0, 1, 2, 3'b000, 3'b000, A2);
    add(0, 3'b100, 1, 1, 2, 3'b100, 3'b000, A2);
    add(0, 3'b000, 0, 0, 2, 3'b000, 3'b000, A2);
    add(0, 3'b010, 0, 0, 2, 3'b000, 3'b000, A2); // reset mid-transaction
    add(0, 3'b010, 0, 1, 1, 3'b000, 3'b000, A1);
    add(1, 3'b010, 0, 1, 1, 3'b000, 3'b000, A1);
    add(0, 3'b011, 1, 0, 0, 3'b000, 3'b000, A0);
    add(0, 3'b011, 1, 1, 0, 3'b001, 3'b000, A0);
    add(0, 3'b010, 1, 0, 0, 3'b000, 3'b000, A0);
    add(0, 3'b010, 1, 1, 1, 3'b010, 3'b000, A1);
    add(0, 3'b000, 0, 0, 1, 3'b000, 3'b000, A1);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      logic [31:0] rd;
      rd = 32'hD000_0000 + 32'(i);
      @(negedge clk);
      reset         = vecs[i].rst;
      bus.req_valid = vecs[i].vld;
      bus.mem_ready = vecs[i].mrdy;
      bus.mem_rdata = rd;
      #1;
      chk($sformatf("row%0d_mem_valid", i), 64'(bus.mem_valid), 64'(vecs[i].mv));
      chk($sformatf("row%0d_busy", i),      64'(bus.busy),      64'(vecs[i].mv));
      chk($sformatf("row%0d_grant", i),     64'(bus.grant_idx), 64'(vecs[i].g));
      chk($sformatf("row%0d_req_ready", i), 64'(bus.req_ready), 64'(vecs[i].rdy));
      chk($sformatf("row%0d_req_err", i),   64'(bus.req_err),   64'(vecs[i].err));
      chk($sformatf("row%0d_mem_addr", i),  64'(bus.mem_addr),  64'(vecs[i].addr));
      chk($sformatf("row%0d_req_rdata", i), 64'(bus.req_rdata), 64'(rd));
    end

    // Grant is held after req_valid drops; write payload steered from requester 0.
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 3'b001;
    bus.mem_ready = 1'b0;
    #1;
    chk("hold_idle", 64'(bus.mem_valid), 64'd0);
    @(negedge clk);
    bus.req_valid = 3'b000;
    #1;
    chk("hold_mv0", 64'(bus.mem_valid), 64'd1);
    chk("hold_grant", 64'(bus.grant_idx), 64'd0);
    chk("hold_wdata", 64'(bus.mem_wdata), 64'(W0));
    chk("hold_wstrb", 64'(bus.mem_wstrb), 64'h1);
    @(negedge clk);
    #1;
    chk("hold_mv1", 64'(bus.mem_valid), 64'd1);
    chk("hold_rdy_none", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    #1;
    chk("hold_rdy", 64'(bus.req_ready), 64'b001);
    chk("hold_err", 64'(bus.req_err), 64'd0);
    chk("hold_rdata", 64'(bus.req_rdata), 64'h1234_5678);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("hold_done", 64'(bus.mem_valid), 64'd0);

    // Bounded grant wait and timeout count on requester 2 with a silent memory.
    begin
      int cyc;
      int bcnt;
      cyc = 0;
      bus.req_valid = 3'b100;
      #1;
      while (!bus.mem_valid && cyc < 8) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      chk("to_grant_latency", 64'(cyc), 64'd1);
      chk("to_wstrb", 64'(bus.mem_wstrb), 64'hF);
      chk("to_wdata", 64'(bus.mem_wdata), 64'(W2));
      bcnt = 0;
      while (!bus.req_ready[2] && bcnt < 8) begin
        @(negedge clk);
        #1;
        bcnt++;
      end
      chk("to_cycle_index", 64'(bcnt), 64'd3);
      chk("to_err", 64'(bus.req_err), 64'b100);
      chk("to_rdy", 64'(bus.req_ready), 64'b100);
      @(negedge clk);
      bus.req_valid = 3'b000;
      #1;
      chk("to_after", 64'(bus.mem_valid), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
